fft_frame_sched: RTL and testbench

- Sequencer between the serial FIR sample stream and the 16-point FFT butterfly core.
- Packs incoming samples into 16-sample frames using a ping-pong buffer and launches the core once per frame.
- Captures each core result and presents it on the 16-lane output bus: real parts in one cycle, imaginary parts in the next.
- Counts completed frames and raises done after the last one.

---
 rtl/fft_frame_sched.sv | 186 ++++++++++++++++++
 tb/tb_fft_frame_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: packs the serial FIR stream into 16-sample ping-pong frames, launches the
// 16-point FFT core once per frame and emits each result as a real half then an imaginary half.
// Optional macro FFT_BITREV_EN: reorder bit-reversed core result lanes into natural order.
module fft_frame_sched #(
  parameter int unsigned DW     = 16,
  parameter int unsigned FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fir_valid,
  input  logic [DW-1:0]    fir_d,
  output logic             core_start,
  output logic [16*DW-1:0] core_x,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic [16*DW-1:0] core_re,
  input  logic [16*DW-1:0] core_im,
  output logic             fft_valid,
  output logic [16*DW-1:0] fft_d,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned NPT = 16;
  localparam int unsigned BW  = NPT * DW;
  localparam int unsigned CW  = $clog2(FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_OUT_RE, S_OUT_IM, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wr_ptr_q, wr_ptr_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [BW-1:0]   im_lat_q, im_lat_d;
  logic            core_start_q, core_start_d;
  logic [BW-1:0]   core_x_q, core_x_d;
  logic            fft_valid_q, fft_valid_d;
  logic [BW-1:0]   fft_d_q, fft_d_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;

  logic [DW-1:0]   bank_q [2][NPT];

  // Map captured core lanes onto output lanes.
  function automatic logic [BW-1:0] lane_order(input logic [BW-1:0] x);
    logic [BW-1:0] y;
`ifdef FFT_BITREV_EN
    logic [3:0] k4;
    y = '0;
    for (int k = 0; k < NPT; k++) begin
      k4 = 4'(k);
      y[k*DW +: DW] = x[int'({k4[0], k4[1], k4[2], k4[3]}) * DW +: DW];
    end
`else
    y = x;
`endif
    return y;
  endfunction

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    im_lat_d     = im_lat_q;
    core_start_d = 1'b0;
    core_x_d     = core_x_q;
    fft_valid_d  = 1'b0;
    fft_d_d      = '0;
    done_d       = done_q;
    ovf_d        = ovf_q;
    wr_en        = 1'b0;

    // Fill path: a full target bank drops the sample without moving the pointer.
    if (fir_valid && (in_cnt_q < CW'(FRAMES))) begin
      if (full_q[wr_bank_q]) begin
        ovf_d = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 4'd1;
        if (wr_ptr_q == 4'd15) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          in_cnt_d          = in_cnt_q + CW'(1);
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q] && !core_busy) begin
          state_d      = S_ISSUE;
          core_start_d = 1'b1;
          for (int k = 0; k < NPT; k++) begin
            core_x_d[k*DW +: DW] = bank_q[rd_bank_q][4'(k)];
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          fft_valid_d       = 1'b1;
          fft_d_d           = lane_order(core_re);
          im_lat_d          = lane_order(core_im);
          state_d           = S_OUT_RE;
        end
      end
      S_OUT_RE: begin
        fft_valid_d = 1'b1;
        fft_d_d     = im_lat_q;
        state_d     = S_OUT_IM;
      end
      S_OUT_IM: begin
        out_cnt_d = out_cnt_q + CW'(1);
        if (out_cnt_d == CW'(FRAMES)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  done_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      im_lat_q     <= '0;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      fft_valid_q  <= 1'b0;
      fft_d_q      <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      im_lat_q     <= im_lat_d;
      core_start_q <= core_start_d;
      core_x_q     <= core_x_d;
      fft_valid_q  <= fft_valid_d;
      fft_d_q      <= fft_d_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  // Sample storage; validity is tracked solely by full_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank_q][wr_ptr_q] <= fir_d;
    end
  end

  assign core_start = core_start_q;
  assign core_x     = core_x_q;
  assign fft_valid  = fft_valid_q;
  assign fft_d      = fft_d_q;
  assign done       = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: random sample streams, a latency-programmable core model and a
// frame-level reference that predicts every launched frame and every emitted half-frame.
module tb_fft_frame_sched;

  localparam int unsigned DW     = 16;
  localparam int unsigned FRAMES = 64;
  localparam int unsigned NPT    = 16;
  localparam int unsigned BW     = NPT * DW;

  logic          clk, rst, fir_valid, core_start, core_busy, core_done, fft_valid, done, ovf;
  logic [DW-1:0] fir_d;
  logic [BW-1:0] core_x, core_re, core_im, fft_d;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  lat = 4;
  bit  spur_req = 1'b0;

  logic [DW-1:0] sent_q[$];
  logic [BW-1:0] start_x_q[$];
  logic [BW-1:0] out_q[$];
  int  cyc = 0, start_cnt = 0, val_cnt = 0, last_val_cyc = 0, done_cyc = 0;
  int  bad_run = 0, run_len = 0, start_in_rst = 0;
  bit  done_seen = 1'b0;

  fft_frame_sched #(.DW(DW), .FRAMES(FRAMES)) dut (
    .clk        (clk),
    .rst        (rst),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .core_start (core_start),
    .core_x     (core_x),
    .core_busy  (core_busy),
    .core_done  (core_done),
    .core_re    (core_re),
    .core_im    (core_im),
    .fft_valid  (fft_valid),
    .fft_d      (fft_d),
    .done       (done),
    .ovf        (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: output lane k carries core lane src_lane(k).
  function automatic int src_lane(input int k);
`ifdef FFT_BITREV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  function automatic logic [BW-1:0] model_re(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int j = 0; j < NPT; j++) r[j*DW +: DW] = x[j*DW +: DW] - 16'h0100 + DW'(j);
    return r;
  endfunction

  function automatic logic [BW-1:0] model_im(input logic [BW-1:0] x);
    logic [BW-1:0] r;
    for (int j = 0; j < NPT; j++) r[j*DW +: DW] = x[j*DW +: DW] - 16'h00F0 + DW'(j);
    return r;
  endfunction

  function automatic logic [BW-1:0] exp_frame(input int n);
    logic [BW-1:0] f;
    for (int j = 0; j < NPT; j++) f[j*DW +: DW] = sent_q[n*NPT + j];
    return f;
  endfunction

  function automatic logic [BW-1:0] exp_out(input logic [BW-1:0] x, input bit im);
    logic [BW-1:0] c, y;
    c = im ? model_im(x) : model_re(x);
    for (int k = 0; k < NPT; k++) y[k*DW +: DW] = c[src_lane(k)*DW +: DW];
    return y;
  endfunction

  // Core model: answers each launch after 'lat' cycles; can inject a stray done pulse.
  initial begin : core_model
    logic [BW-1:0] px;
    int pend;
    pend = 0;
    px = '0;
    core_done = 1'b0;
    core_re = '0;
    core_im = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst !== 1'b1) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            core_done = 1'b1;
            core_re = model_re(px);
            core_im = model_im(px);
          end
        end
        if (core_start === 1'b1) begin
          px = core_x;
          pend = lat;
        end
        if (spur_req) begin
          core_done = 1'b1;
          core_re = {8{$urandom}};
          core_im = {8{$urandom}};
          spur_req = 1'b0;
        end
      end
    end
  end

  // Output monitor, sampled 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (rst !== 1'b1 && core_start !== 1'b0) start_in_rst++;
    if (core_start === 1'b1) begin
      start_cnt++;
      start_x_q.push_back(core_x);
    end
    if (fft_valid === 1'b1) begin
      val_cnt++;
      out_q.push_back(fft_d);
      last_val_cyc = cyc;
      run_len++;
    end else begin
      if (run_len != 0 && run_len != 2) bad_run++;
      run_len = 0;
    end
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
  end

  task automatic clear_mon();
    start_cnt = 0; val_cnt = 0; bad_run = 0; run_len = 0; done_seen = 1'b0;
    start_x_q.delete(); out_q.delete(); sent_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; fir_valid = 1'b0; fir_d = '0; core_busy = 1'b0; spur_req = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] v, input bit rec);
    @(negedge clk);
    fir_valid = 1'b1;
    fir_d = v;
    if (rec) sent_q.push_back(v);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      fir_valid = 1'b0;
    end
  endtask

  task automatic wait_vals(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      fir_valid = 1'b0;
      if (val_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({core_start, fft_valid, done, ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {core_start, fft_valid, done, ovf}); end
    n_cmp++; if (core_x !== '0) begin n_fail++; $display("FAIL reset_core_x: got %h expected 0", core_x); end
    n_cmp++; if (fft_d !== '0) begin n_fail++; $display("FAIL reset_fft_d: got %h expected 0", fft_d); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      fir_valid = 1'b1;
      fir_d = DW'($urandom);
    end
    n_cmp++; if ({core_start, fft_valid, done, ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0000", {core_start, fft_valid, done, ovf}); end
    do_reset();
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [BW-1:0] f, exp, got;
    do_reset();
    lat = 4;
    for (int i = 0; i < 16; i++) send(16'h0100, 1'b1);
    wait_vals(2, 60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d valid cycles expected 2", val_cnt); end
    idle_cycles(6);
    for (int j = 0; j < NPT; j++) f[j*DW +: DW] = 16'h0100;
    n_cmp++; if (start_cnt != 1) begin n_fail++; $display("FAIL single_starts: got %0d expected 1", start_cnt); end
    n_cmp++; if (val_cnt != 2 || bad_run != 0) begin n_fail++; $display("FAIL single_valid: got %0d cycles bad_runs %0d expected 2 and 0", val_cnt, bad_run); end
    if (start_x_q.size() >= 1) begin
      n_cmp++; if (start_x_q[0] !== f) begin n_fail++; $display("FAIL single_core_x: got %h expected %h", start_x_q[0], f); end
    end
    if (out_q.size() >= 2) begin
      got = out_q[0]; exp = exp_out(f, 1'b0);
      n_cmp++; if (got[5*DW +: DW] !== exp[5*DW +: DW]) begin n_fail++; $display("FAIL single_re_lane5: got %h expected %h", got[5*DW +: DW], exp[5*DW +: DW]); end
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL single_re: got %h expected %h", got, exp); end
      got = out_q[1]; exp = exp_out(f, 1'b1);
      n_cmp++; if (got[5*DW +: DW] !== exp[5*DW +: DW]) begin n_fail++; $display("FAIL single_im_lane5: got %h expected %h", got[5*DW +: DW], exp[5*DW +: DW]); end
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL single_im: got %h expected %h", got, exp); end
`ifdef FFT_BITREV_EN
      got = out_q[0];
      n_cmp++; if (got[1*DW +: DW] !== 16'd8 || got[3*DW +: DW] !== 16'd12 || got[15*DW +: DW] !== 16'd15) begin n_fail++; $display("FAIL bitrev_lanes: got %h expected lanes1/3/15 = 8/12/15", got); end
`endif
    end
    n_cmp++; if ({done, ovf} !== 2'b00) begin n_fail++; $display("FAIL single_done_ovf: got %b expected 00", {done, ovf}); end
  endtask

  task automatic test_full_run();
    logic [BW-1:0] f;
    do_reset();
    lat = 6;
    for (int i = 0; i < FRAMES * NPT; i++) send(DW'($urandom), 1'b1);
    for (int i = 0; i < 20; i++) send(DW'($urandom), 1'b0);
    for (int i = 0; i < 500 && !done_seen; i++) idle_cycles(1);
    n_cmp++; if (!done_seen) begin n_fail++; $display("FAIL full_done_timeout: got done=%b expected 1", done); end
    idle_cycles(10);
    n_cmp++; if (start_cnt != FRAMES) begin n_fail++; $display("FAIL full_starts: got %0d expected %0d", start_cnt, FRAMES); end
    n_cmp++; if (val_cnt != 2 * FRAMES) begin n_fail++; $display("FAIL full_valid: got %0d expected %0d", val_cnt, 2 * FRAMES); end
    n_cmp++; if (done_cyc != last_val_cyc + 1) begin n_fail++; $display("FAIL full_done_timing: got cycle %0d expected %0d", done_cyc, last_val_cyc + 1); end
    n_cmp++; if ({done, ovf} !== 2'b10 || bad_run != 0) begin n_fail++; $display("FAIL full_flags: got done/ovf %b bad_runs %0d expected 10 and 0", {done, ovf}, bad_run); end
    for (int n = 0; n < FRAMES && n < start_x_q.size() && 2 * n + 1 < out_q.size(); n++) begin
      f = exp_frame(n);
      n_cmp++; if (start_x_q[n] !== f) begin n_fail++; $display("FAIL full_core_x[%0d]: got %h expected %h", n, start_x_q[n], f); end
      n_cmp++; if (out_q[2*n] !== exp_out(f, 1'b0)) begin n_fail++; $display("FAIL full_re[%0d]: got %h expected %h", n, out_q[2*n], exp_out(f, 1'b0)); end
      n_cmp++; if (out_q[2*n+1] !== exp_out(f, 1'b1)) begin n_fail++; $display("FAIL full_im[%0d]: got %h expected %h", n, out_q[2*n+1], exp_out(f, 1'b1)); end
    end
  endtask

  task automatic test_busy_overflow();
    bit ok;
    logic [DW-1:0] v;
    logic [BW-1:0] f;
    do_reset();
    lat = 4;
    core_busy = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 32) begin
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL busy_ovf_early: got %b expected 0", ovf); end
      end
      if (i == 40) begin
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL busy_ovf: got %b expected 1", ovf); end
        n_cmp++; if (start_cnt != 0) begin n_fail++; $display("FAIL busy_no_start: got %0d expected 0", start_cnt); end
        core_busy = 1'b0;
      end
      v = DW'($urandom);
      fir_valid = 1'b1;
      fir_d = v;
      if (i < 32) sent_q.push_back(v);
    end
    wait_vals(4, 120, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_timeout: got %0d valid cycles expected 4", val_cnt); end
    for (int n = 0; n < 2 && n < start_x_q.size(); n++) begin
      f = exp_frame(n);
      n_cmp++; if (start_x_q[n] !== f) begin n_fail++; $display("FAIL busy_core_x[%0d]: got %h expected %h", n, start_x_q[n], f); end
    end
    if (out_q.size() >= 2) begin
      f = exp_frame(0);
      n_cmp++; if (out_q[0] !== exp_out(f, 1'b0) || out_q[1] !== exp_out(f, 1'b1)) begin n_fail++; $display("FAIL busy_out0: got %h / %h expected %h / %h", out_q[0], out_q[1], exp_out(f, 1'b0), exp_out(f, 1'b1)); end
    end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL busy_ovf_sticky: got %b expected 1", ovf); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok, hit;
    logic [BW-1:0] f;
    do_reset();
    lat = 6;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      send(DW'($urandom), 1'b1);
      if (start_cnt == 3) hit = 1'b1;
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL midrst_timeout: got %0d starts expected 3", start_cnt); end
    send(DW'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b0;
    fir_valid = 1'b0;
    #1;
    n_cmp++; if ({core_start, fft_valid, done, ovf} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {core_start, fft_valid, done, ovf}); end
    n_cmp++; if (core_x !== '0 || fft_d !== '0) begin n_fail++; $display("FAIL midrst_buses: got %h / %h expected 0", core_x, fft_d); end
    repeat (2) @(negedge clk);
    clear_mon();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send(DW'($urandom), 1'b1);
    wait_vals(2, 60, ok);
    idle_cycles(4);
    n_cmp++; if (!ok || start_cnt != 1) begin n_fail++; $display("FAIL midrst_relaunch: got %0d starts %0d valids expected 1 and 2", start_cnt, val_cnt); end
    if (start_x_q.size() >= 1 && out_q.size() >= 2) begin
      f = exp_frame(0);
      n_cmp++; if (start_x_q[0] !== f) begin n_fail++; $display("FAIL midrst_core_x: got %h expected %h", start_x_q[0], f); end
      n_cmp++; if (out_q[0] !== exp_out(f, 1'b0) || out_q[1] !== exp_out(f, 1'b1)) begin n_fail++; $display("FAIL midrst_out: got %h / %h expected %h / %h", out_q[0], out_q[1], exp_out(f, 1'b0), exp_out(f, 1'b1)); end
    end
    n_cmp++; if (start_in_rst != 0) begin n_fail++; $display("FAIL midrst_start_glitch: got %0d expected 0", start_in_rst); end
  endtask

  task automatic test_spurious_done();
    bit ok;
    logic [BW-1:0] f;
    do_reset();
    lat = 3;
    idle_cycles(3);
    spur_req = 1'b1;
    idle_cycles(6);
    n_cmp++; if (val_cnt != 0 || fft_d !== '0) begin n_fail++; $display("FAIL spur_idle: got %0d valids fft_d %h expected 0", val_cnt, fft_d); end
    for (int i = 0; i < 8; i++) send(DW'($urandom), 1'b1);
    spur_req = 1'b1;
    idle_cycles(4);
    n_cmp++; if (val_cnt != 0 || start_cnt != 0) begin n_fail++; $display("FAIL spur_partial: got %0d valids %0d starts expected 0 and 0", val_cnt, start_cnt); end
    for (int i = 0; i < 8; i++) send(DW'($urandom), 1'b1);
    wait_vals(2, 60, ok);
    idle_cycles(4);
    n_cmp++; if (!ok || start_cnt != 1 || val_cnt != 2) begin n_fail++; $display("FAIL spur_frame: got %0d starts %0d valids expected 1 and 2", start_cnt, val_cnt); end
    if (out_q.size() >= 2) begin
      f = exp_frame(0);
      n_cmp++; if (out_q[0] !== exp_out(f, 1'b0) || out_q[1] !== exp_out(f, 1'b1)) begin n_fail++; $display("FAIL spur_out: got %h / %h expected %h / %h", out_q[0], out_q[1], exp_out(f, 1'b0), exp_out(f, 1'b1)); end
    end
  endtask

  task automatic test_random_gaps();
    bit ok;
    logic [BW-1:0] f;
    do_reset();
    lat = $urandom_range(1, 10);
    while (sent_q.size() < 5 * NPT) begin
      if ($urandom_range(0, 9) < 7) send(DW'($urandom), 1'b1);
      else idle_cycles(1);
    end
    wait_vals(10, 300, ok);
    idle_cycles(4);
    n_cmp++; if (!ok || start_cnt != 5) begin n_fail++; $display("FAIL rand_counts: got %0d starts %0d valids (lat %0d) expected 5 and 10", start_cnt, val_cnt, lat); end
    n_cmp++; if ({done, ovf} !== 2'b00 || bad_run != 0) begin n_fail++; $display("FAIL rand_flags: got done/ovf %b bad_runs %0d expected 00 and 0", {done, ovf}, bad_run); end
    for (int n = 0; n < 5 && n < start_x_q.size() && 2 * n + 1 < out_q.size(); n++) begin
      f = exp_frame(n);
      n_cmp++; if (start_x_q[n] !== f) begin n_fail++; $display("FAIL rand_core_x[%0d]: got %h expected %h", n, start_x_q[n], f); end
      n_cmp++; if (out_q[2*n] !== exp_out(f, 1'b0) || out_q[2*n+1] !== exp_out(f, 1'b1)) begin n_fail++; $display("FAIL rand_out[%0d]: got %h / %h expected %h / %h", n, out_q[2*n], out_q[2*n+1], exp_out(f, 1'b0), exp_out(f, 1'b1)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    fir_valid = 1'b0;
    fir_d = '0;
    core_busy = 1'b0;
    test_reset();
    test_single_frame();
    test_full_run();
    test_busy_overflow();
    test_reset_mid_wait();
    test_spurious_done();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
